// File: rtl/dfi_lp_pkg.sv
// Shared types and defaults for the DFI low-power request sequencer.
//   lp_state_e : per-channel sequencer state
//   wakeup_t   : wakeup code at the default width
//   *_DFLT     : default parameter values used by the interface and top
package dfi_lp_pkg;

  localparam int unsigned WAKEUP_W_DFLT = 6;
  localparam int unsigned CNT_W_DFLT    = 5;
  localparam int unsigned TLP_RESP_DFLT = 7;
  localparam int unsigned TLP_EXIT_DFLT = 16;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    REQ    = 3'd1,
    ACTIVE = 3'd2,
    EXIT   = 3'd3,
    HOLD   = 3'd4
  } lp_state_e;

  typedef logic [WAKEUP_W_DFLT-1:0] wakeup_t;

endpackage

// File: rtl/dfi_lp_req_seq_if.sv
// Host/PHY-facing signal bundle of the DFI low-power request sequencer.
//   master : sequencer view (drives lp_*_req/wakeup and host status pulses)
//   slave  : host + PHY view (drives enables, wakeup codes, acks, init_start)
interface dfi_lp_req_seq_if #(
  parameter int unsigned WAKEUP_W = dfi_lp_pkg::WAKEUP_W_DFLT
);

  logic                init_start;

  logic                ctrl_en;
  logic [WAKEUP_W-1:0] ctrl_wakeup_in;
  logic                lp_ctrl_ack;
  logic                lp_ctrl_req;
  logic [WAKEUP_W-1:0] lp_ctrl_wakeup;
  logic                ctrl_active;
  logic                ctrl_timeout;
  logic                ctrl_err;

  logic                data_en;
  logic [WAKEUP_W-1:0] data_wakeup_in;
  logic                lp_data_ack;
  logic                lp_data_req;
  logic [WAKEUP_W-1:0] lp_data_wakeup;
  logic                data_active;
  logic                data_timeout;
  logic                data_err;

  modport master (
    input  init_start,
    input  ctrl_en, ctrl_wakeup_in, lp_ctrl_ack,
    output lp_ctrl_req, lp_ctrl_wakeup, ctrl_active, ctrl_timeout, ctrl_err,
    input  data_en, data_wakeup_in, lp_data_ack,
    output lp_data_req, lp_data_wakeup, data_active, data_timeout, data_err
  );

  modport slave (
    output init_start,
    output ctrl_en, ctrl_wakeup_in, lp_ctrl_ack,
    input  lp_ctrl_req, lp_ctrl_wakeup, ctrl_active, ctrl_timeout, ctrl_err,
    output data_en, data_wakeup_in, lp_data_ack,
    input  lp_data_req, lp_data_wakeup, data_active, data_timeout, data_err
  );

endinterface

// File: rtl/dfi_lp_chan_fsm.sv
// One DFI low-power channel: request FSM, response/exit timeout counter,
// wakeup latch and status pulses. All outputs are registered; the top
// applies the init_start gating to req.
//   clock, reset : clock and async active-low reset
//   init_start   : DFI init in progress, cancels/inhibits requests
//   en           : host level request
//   wakeup_in    : host wakeup code, sampled on IDLE -> REQ
//   ack          : PHY acknowledge
//   req          : raw (ungated) request
//   wakeup       : latched wakeup code
//   active       : high while in ACTIVE
//   timeout      : one-cycle pulse on response or exit timeout
//   err          : one-cycle pulse per spurious ack cycle
module dfi_lp_chan_fsm
  import dfi_lp_pkg::*;
#(
  parameter int unsigned TLP_RESP = TLP_RESP_DFLT,
  parameter int unsigned TLP_EXIT = TLP_EXIT_DFLT,
  parameter int unsigned WAKEUP_W = WAKEUP_W_DFLT,
  // 2**CNT_W must exceed max(TLP_RESP, TLP_EXIT)
  parameter int unsigned CNT_W    = CNT_W_DFLT
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                init_start,
  input  logic                en,
  input  logic [WAKEUP_W-1:0] wakeup_in,
  input  logic                ack,
  output logic                req,
  output logic [WAKEUP_W-1:0] wakeup,
  output logic                active,
  output logic                timeout,
  output logic                err
);

  // Counter values seen during the final allowed cycle of each wait
  localparam logic [CNT_W-1:0] RESP_LAST = CNT_W'(TLP_RESP - 1);
  localparam logic [CNT_W-1:0] EXIT_LAST = CNT_W'(TLP_EXIT - 1);
  localparam logic [CNT_W-1:0] CNT_MAX   = '1;

  lp_state_e           state, state_nx;
  logic [CNT_W-1:0]    cnt, cnt_nx, cnt_inc;
  logic                req_nx, active_nx, timeout_nx, err_nx;
  logic [WAKEUP_W-1:0] wakeup_nx;

  // Saturating increment
  assign cnt_inc = (cnt == CNT_MAX) ? cnt : cnt + CNT_W'(1);

  // State, counter and output registers
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state   <= IDLE;
      cnt     <= '0;
      req     <= 1'b0;
      wakeup  <= '0;
      active  <= 1'b0;
      timeout <= 1'b0;
      err     <= 1'b0;
    end else begin
      state   <= state_nx;
      cnt     <= cnt_nx;
      req     <= req_nx;
      wakeup  <= wakeup_nx;
      active  <= active_nx;
      timeout <= timeout_nx;
      err     <= err_nx;
    end
  end

  // Next-state, counter and output decode
  always_comb begin
    state_nx   = state;
    cnt_nx     = cnt;
    wakeup_nx  = wakeup;
    timeout_nx = 1'b0;
    err_nx     = 1'b0;
    req_nx     = 1'b0;
    active_nx  = 1'b0;

    case (state)
      IDLE: begin
        err_nx = ack;
        if (en && !init_start) begin
          state_nx  = REQ;
          wakeup_nx = wakeup_in;
        end
      end

      REQ: begin
        // Withdrawal and init cancel beat a same-cycle ack; ack beats timeout
        if (init_start || !en) begin
          state_nx = EXIT;
        end else if (ack) begin
          state_nx = ACTIVE;
        end else if (cnt == RESP_LAST) begin
          state_nx   = HOLD;
          timeout_nx = 1'b1;
        end else begin
          cnt_nx = cnt_inc;
        end
      end

      ACTIVE: begin
        if (init_start || !en) begin
          state_nx = EXIT;
        end
      end

      EXIT: begin
        if (!ack) begin
          state_nx = IDLE;
        end else if (cnt == EXIT_LAST) begin
          state_nx   = IDLE;
          timeout_nx = 1'b1;
        end else begin
          cnt_nx = cnt_inc;
        end
      end

      HOLD: begin
        // No retry after a response timeout until the host drops en
        err_nx = ack;
        if (!en) begin
          state_nx = IDLE;
        end
      end

      default: begin
        state_nx = IDLE;
      end
    endcase

    if (state_nx != state) begin
      cnt_nx = '0;
    end

    req_nx    = (state_nx == REQ) || (state_nx == ACTIVE);
    active_nx = (state_nx == ACTIVE);
  end

endmodule

// File: rtl/dfi_lp_req_seq.sv
// MC-side DFI low-power request sequencer: two independent channels
// (ctrl, data) turning host level requests into lp_*_req/ack handshakes.
//   clock, reset : clock and async active-low reset
//   bus          : host/PHY signal bundle (master view)
// init_start gates both requests combinationally so req is never seen
// high together with init_start.
module dfi_lp_req_seq
  import dfi_lp_pkg::*;
#(
  parameter int unsigned TLP_RESP = TLP_RESP_DFLT,
  parameter int unsigned TLP_EXIT = TLP_EXIT_DFLT,
  parameter int unsigned WAKEUP_W = WAKEUP_W_DFLT,
  parameter int unsigned CNT_W    = CNT_W_DFLT
) (
  input  logic             clock,
  input  logic             reset,
  dfi_lp_req_seq_if.master bus
);

  logic ctrl_req;
  logic data_req;

  // Ctrl channel
  dfi_lp_chan_fsm #(
    .TLP_RESP (TLP_RESP),
    .TLP_EXIT (TLP_EXIT),
    .WAKEUP_W (WAKEUP_W),
    .CNT_W    (CNT_W)
  ) u_ctrl (
    .clock      (clock),
    .reset      (reset),
    .init_start (bus.init_start),
    .en         (bus.ctrl_en),
    .wakeup_in  (bus.ctrl_wakeup_in),
    .ack        (bus.lp_ctrl_ack),
    .req        (ctrl_req),
    .wakeup     (bus.lp_ctrl_wakeup),
    .active     (bus.ctrl_active),
    .timeout    (bus.ctrl_timeout),
    .err        (bus.ctrl_err)
  );

  // Data channel
  dfi_lp_chan_fsm #(
    .TLP_RESP (TLP_RESP),
    .TLP_EXIT (TLP_EXIT),
    .WAKEUP_W (WAKEUP_W),
    .CNT_W    (CNT_W)
  ) u_data (
    .clock      (clock),
    .reset      (reset),
    .init_start (bus.init_start),
    .en         (bus.data_en),
    .wakeup_in  (bus.data_wakeup_in),
    .ack        (bus.lp_data_ack),
    .req        (data_req),
    .wakeup     (bus.lp_data_wakeup),
    .active     (bus.data_active),
    .timeout    (bus.data_timeout),
    .err        (bus.data_err)
  );

  assign bus.lp_ctrl_req = ctrl_req & ~bus.init_start;
  assign bus.lp_data_req = data_req & ~bus.init_start;

endmodule

// File: tb/tb_dfi_lp_req_seq.sv
// Scoreboard bench for dfi_lp_req_seq: stimulus pushes the outputs a
// behavioural model predicts; a negedge monitor pops and compares.
module tb_dfi_lp_req_seq;
  import dfi_lp_pkg::*;

  localparam int TLP_RESP = 7;
  localparam int TLP_EXIT = 16;

  localparam int M_IDLE = 0;
  localparam int M_REQ  = 1;
  localparam int M_ACT  = 2;
  localparam int M_EXIT = 3;
  localparam int M_HOLD = 4;

  typedef struct {
    int      mode;
    int      age;
    wakeup_t wk;
    bit      to;
    bit      err;
  } mdl_t;

  typedef struct {
    bit      req;
    wakeup_t wk;
    bit      act;
    bit      to;
    bit      err;
  } ch_obs_t;

  typedef struct {
    ch_obs_t c;
    ch_obs_t d;
  } obs_t;

  logic clock;
  logic reset;

  dfi_lp_req_seq_if #(.WAKEUP_W(WAKEUP_W_DFLT)) bus();

  dfi_lp_req_seq #(
    .TLP_RESP (TLP_RESP),
    .TLP_EXIT (TLP_EXIT),
    .WAKEUP_W (WAKEUP_W_DFLT),
    .CNT_W    (CNT_W_DFLT)
  ) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  int   checks = 0;
  int   errors = 0;
  obs_t sb[$];
  mdl_t mc, md;

  bit      init_i, cen, cack, den, dack;
  wakeup_t cwk, dwk;

  task automatic cmp(input string name, input int unsigned act, input int unsigned exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic mdl_t mdl_reset();
    mdl_t m;
    m.mode = M_IDLE;
    m.age  = 0;
    m.wk   = '0;
    m.to   = 1'b0;
    m.err  = 1'b0;
    return m;
  endfunction

  // Outputs visible now, given the model's registered view and current init_start
  function automatic ch_obs_t mdl_view(mdl_t m, bit init);
    ch_obs_t o;
    o.req = ((m.mode == M_REQ) || (m.mode == M_ACT)) && !init;
    o.wk  = m.wk;
    o.act = (m.mode == M_ACT);
    o.to  = m.to;
    o.err = m.err;
    return o;
  endfunction

  // One clock of channel behaviour; age counts cycles spent waiting on ack
  function automatic mdl_t mdl_step(mdl_t m, bit init, bit en, wakeup_t wi, bit ack);
    mdl_t n;
    n     = m;
    n.to  = 1'b0;
    n.err = 1'b0;
    case (m.mode)
      M_IDLE: begin
        n.err = ack;
        if (en && !init) begin
          n.mode = M_REQ;
          n.wk   = wi;
        end
      end
      M_REQ: begin
        if (init || !en) n.mode = M_EXIT;
        else if (ack) n.mode = M_ACT;
        else begin
          n.age = m.age + 1;
          if (n.age >= TLP_RESP) begin
            n.mode = M_HOLD;
            n.to   = 1'b1;
          end
        end
      end
      M_ACT: if (init || !en) n.mode = M_EXIT;
      M_EXIT: begin
        if (!ack) n.mode = M_IDLE;
        else begin
          n.age = m.age + 1;
          if (n.age >= TLP_EXIT) begin
            n.mode = M_IDLE;
            n.to   = 1'b1;
          end
        end
      end
      M_HOLD: begin
        n.err = ack;
        if (!en) n.mode = M_IDLE;
      end
      default: n.mode = M_IDLE;
    endcase
    if (n.mode != m.mode) n.age = 0;
    return n;
  endfunction

  task automatic apply_inputs();
    bus.init_start     = init_i;
    bus.ctrl_en        = cen;
    bus.ctrl_wakeup_in = cwk;
    bus.lp_ctrl_ack    = cack;
    bus.data_en        = den;
    bus.data_wakeup_in = dwk;
    bus.lp_data_ack    = dack;
  endtask

  // Drive one cycle of inputs, record the expected observation, advance the model
  task automatic tick();
    obs_t e;
    @(posedge clock);
    #1;
    apply_inputs();
    e.c = mdl_view(mc, init_i);
    e.d = mdl_view(md, init_i);
    sb.push_back(e);
    mc = mdl_step(mc, init_i, cen, cwk, cack);
    md = mdl_step(md, init_i, den, dwk, dack);
  endtask

  task automatic chk_zero(input string tag);
    cmp({tag, "_ctrl_req"}, bus.lp_ctrl_req, 0);
    cmp({tag, "_ctrl_wk"},  bus.lp_ctrl_wakeup, 0);
    cmp({tag, "_ctrl_act"}, bus.ctrl_active, 0);
    cmp({tag, "_ctrl_to"},  bus.ctrl_timeout, 0);
    cmp({tag, "_ctrl_err"}, bus.ctrl_err, 0);
    cmp({tag, "_data_req"}, bus.lp_data_req, 0);
    cmp({tag, "_data_wk"},  bus.lp_data_wakeup, 0);
    cmp({tag, "_data_act"}, bus.data_active, 0);
    cmp({tag, "_data_to"},  bus.data_timeout, 0);
    cmp({tag, "_data_err"}, bus.data_err, 0);
  endtask

  // Monitor: every negedge with a pending expectation is a compare point
  initial begin
    forever begin
      @(negedge clock);
      if (sb.size() > 0) begin
        obs_t e;
        e = sb.pop_front();
        cmp("ctrl_req",     bus.lp_ctrl_req,    e.c.req);
        cmp("ctrl_wakeup",  bus.lp_ctrl_wakeup, e.c.wk);
        cmp("ctrl_active",  bus.ctrl_active,    e.c.act);
        cmp("ctrl_timeout", bus.ctrl_timeout,   e.c.to);
        cmp("ctrl_err",     bus.ctrl_err,       e.c.err);
        cmp("data_req",     bus.lp_data_req,    e.d.req);
        cmp("data_wakeup",  bus.lp_data_wakeup, e.d.wk);
        cmp("data_active",  bus.data_active,    e.d.act);
        cmp("data_timeout", bus.data_timeout,   e.d.to);
        cmp("data_err",     bus.data_err,       e.d.err);
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int n_req, n_to, n_err;
    clock  = 1'b0;
    reset  = 1'b0;
    init_i = 1'b0; cen = 1'b0; cack = 1'b0; den = 1'b0; dack = 1'b0;
    cwk    = '0;   dwk = '0;
    apply_inputs();
    mc = mdl_reset();
    md = mdl_reset();
    #12;
    chk_zero("rst");
    #16;
    reset = 1'b1;

    // Basic ctrl entry/exit with wakeup change while ACTIVE
    cen = 1'b1; cwk = 6'h0A;
    tick(); tick(); tick();
    cack = 1'b1;
    tick(); tick(); tick();
    cwk = 6'h3F;
    tick(); tick(); tick();
    @(negedge clock);
    cmp("wk_stable", bus.lp_ctrl_wakeup, 6'h0A);
    cen = 1'b0;
    tick(); tick();
    cack = 1'b0;
    tick(); tick(); tick();

    // Data response timeout, no retry while en stays high
    den = 1'b1; dwk = 6'h15;
    n_req = 0; n_to = 0;
    for (int k = 0; k < 12; k++) begin
      tick();
      @(negedge clock);
      if (bus.lp_data_req) n_req++;
      if (bus.data_timeout) n_to++;
    end
    cmp("resp_req_cycles", n_req, TLP_RESP);
    cmp("resp_to_pulses", n_to, 1);
    den = 1'b0;
    tick();
    den = 1'b1; dwk = 6'h2C;
    tick(); tick();
    @(negedge clock);
    cmp("rereq", bus.lp_data_req, 1);
    den = 1'b0;
    tick(); tick(); tick();

    // init_start cancel with ctrl ACTIVE and data in REQ
    cen = 1'b1; cwk = 6'h11; den = 1'b1; dwk = 6'h22;
    tick(); tick();
    cack = 1'b1;
    tick(); tick(); tick();
    init_i = 1'b1;
    tick();
    @(negedge clock);
    cmp("init_ctrl_req", bus.lp_ctrl_req, 0);
    cmp("init_data_req", bus.lp_data_req, 0);
    tick(); tick();
    cack = 1'b0;
    tick();
    init_i = 1'b0; cen = 1'b0; den = 1'b0;
    tick(); tick(); tick();

    // Exit timeout followed by spurious ack in IDLE
    cen = 1'b1; cwk = 6'h05;
    tick();
    cack = 1'b1;
    tick(); tick(); tick();
    cen = 1'b0;
    n_to = 0; n_err = 0;
    for (int k = 1; k <= 21; k++) begin
      cack = (k <= 20);
      tick();
      @(negedge clock);
      if (bus.ctrl_timeout) n_to++;
      if (bus.ctrl_err) n_err++;
    end
    cmp("exit_to_pulses", n_to, 1);
    cmp("idle_err_pulses", n_err, 3);
    tick(); tick();

    // Async reset in the middle of ACTIVE
    cen = 1'b1; cwk = 6'h33; den = 1'b1; dwk = 6'h0C;
    tick();
    cack = 1'b1; dack = 1'b1;
    tick(); tick(); tick();
    @(negedge clock);
    #2;
    reset = 1'b0;
    #1;
    chk_zero("async");
    init_i = 1'b0; cen = 1'b0; cack = 1'b0; den = 1'b0; dack = 1'b0;
    apply_inputs();
    @(posedge clock);
    #2;
    chk_zero("inrst");
    @(negedge clock);
    #1;
    reset = 1'b1;
    mc = mdl_reset();
    md = mdl_reset();
    tick(); tick(); tick(); tick();

    // Randomized traffic against the model
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 7) == 0) cen = !cen;
      if ($urandom_range(0, 7) == 0) den = !den;
      if ($urandom_range(0, 3) == 0) cack = !cack;
      if ($urandom_range(0, 3) == 0) dack = !dack;
      cwk    = wakeup_t'($urandom);
      dwk    = wakeup_t'($urandom);
      init_i = ($urandom_range(0, 39) == 0);
      tick();
    end

    init_i = 1'b0; cen = 1'b0; cack = 1'b0; den = 1'b0; dack = 1'b0;
    tick(); tick(); tick();
    @(negedge clock);
    #1;
    cmp("sb_drain", sb.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
